// File: rtl/veerwolf_sevseg_pkg.sv
// Shared definitions for the seven-segment scanner: register map, scan FSM states
// and the circular search for the next enabled digit.
package veerwolf_sevseg_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_DIGITS = 2'd1;
  localparam logic [1:0] REG_TIMING = 2'd2;
  localparam logic [1:0] REG_BRIGHT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } scan_state_e;

  // First set mask bit after idx, wrapping; idx itself is tried last.
  function automatic logic [2:0] next_set(input logic [7:0] mask, input logic [2:0] idx);
    logic [2:0] cand;
    logic       found;
    next_set = idx;
    found    = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cand = idx + k[2:0];
      if (!found && mask[cand]) begin
        next_set = cand;
        found    = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/sevseg_hex_decode.sv
// Combinational hex digit to seven-segment decoder, active-low, bit order abc_defg.
module sevseg_hex_decode (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'b111_1111;
    case (nibble_i)
      4'h0: seg_o = 7'b000_0001;
      4'h1: seg_o = 7'b100_1111;
      4'h2: seg_o = 7'b001_0010;
      4'h3: seg_o = 7'b000_0110;
      4'h4: seg_o = 7'b100_1100;
      4'h5: seg_o = 7'b010_0100;
      4'h6: seg_o = 7'b010_0000;
      4'h7: seg_o = 7'b000_1111;
      4'h8: seg_o = 7'b000_0000;
      4'h9: seg_o = 7'b000_0100;
      4'hA: seg_o = 7'b000_1000;
      4'hB: seg_o = 7'b110_0000;
      4'hC: seg_o = 7'b011_0001;
      4'hD: seg_o = 7'b100_0010;
      4'hE: seg_o = 7'b011_0000;
      4'hF: seg_o = 7'b011_1000;
      default: seg_o = 7'b111_1111;
    endcase
  end

endmodule

// File: rtl/veerwolf_sevseg_scanner.sv
// Wishbone-configured eight-digit seven-segment scan sequencer with tear-free digit updates.
// Define SEVSEG_PWM_EN to add per-slot PWM brightness control through the BRIGHT register.
module veerwolf_sevseg_scanner
  import veerwolf_sevseg_pkg::*;
#(
  parameter logic [15:0] DWELL_RST = 16'd50000,
  parameter logic [7:0]  BLANK_RST = 8'd16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic [7:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_frame
);

  logic        ack_q;
  logic [31:0] rdt_q;
  logic [31:0] rd_data;
  logic        wb_req;
  logic        wb_wr;
  logic [1:0]  reg_sel;
  logic        unused_adr;

  logic [7:0]  mask_q;
  logic        scan_en_q;
  logic [31:0] shadow_q;
  logic [31:0] active_q;
  logic [15:0] dwell_q;
  logic [7:0]  blank_q;
  logic [7:0]  duty_rd;

  scan_state_e state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic        boundary;
  logic        run;
  logic [2:0]  nxt_idx;
  logic [2:0]  first_idx;
  logic [15:0] dwell_load;
  logic [15:0] blank_load;
  logic        pwm_on;

  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        frame_q;
  logic [6:0]  hex_seg;

  assign reg_sel    = i_wb_adr[3:2];
  assign unused_adr = ^i_wb_adr[1:0];
  assign wb_req     = i_wb_cyc & i_wb_stb & ~ack_q;
  assign wb_wr      = wb_req & i_wb_we;

  // Bus acknowledge and registered read data
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ack_q <= 1'b0;
      rdt_q <= 32'd0;
    end else begin
      ack_q <= wb_req;
      rdt_q <= (wb_req && !i_wb_we) ? rd_data : 32'd0;
    end
  end

  always_comb begin
    rd_data = 32'd0;
    case (reg_sel)
      REG_CTRL:   rd_data = {23'd0, scan_en_q, mask_q};
      REG_DIGITS: rd_data = shadow_q;
      REG_TIMING: rd_data = {8'd0, blank_q, dwell_q};
      REG_BRIGHT: rd_data = {16'd0, 5'd0, idx_q, duty_rd};
      default:    rd_data = 32'd0;
    endcase
  end

  // Configuration registers, byte lanes honoured
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mask_q    <= 8'd0;
      scan_en_q <= 1'b0;
      shadow_q  <= 32'd0;
      dwell_q   <= DWELL_RST;
      blank_q   <= BLANK_RST;
    end else if (wb_wr) begin
      case (reg_sel)
        REG_CTRL: begin
          if (i_wb_sel[0]) mask_q    <= i_wb_dat[7:0];
          if (i_wb_sel[1]) scan_en_q <= i_wb_dat[8];
        end
        REG_DIGITS: begin
          for (int b = 0; b < 4; b++) begin
            if (i_wb_sel[b]) shadow_q[b*8 +: 8] <= i_wb_dat[b*8 +: 8];
          end
        end
        REG_TIMING: begin
          if (i_wb_sel[0]) dwell_q[7:0]  <= i_wb_dat[7:0];
          if (i_wb_sel[1]) dwell_q[15:8] <= i_wb_dat[15:8];
          if (i_wb_sel[2]) blank_q       <= i_wb_dat[23:16];
        end
        default: ;
      endcase
    end
  end

`ifdef SEVSEG_PWM_EN
  logic [7:0] duty_q;
  logic [7:0] pwm_cnt_q;
  logic       on_load;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      duty_q <= 8'hFF;
    end else if (wb_wr && reg_sel == REG_BRIGHT && i_wb_sel[0]) begin
      duty_q <= i_wb_dat[7:0];
    end
  end

  // The PWM phase restarts with every slot so each digit gets the same duty.
  assign on_load = (state_d == ST_ON) && ((state_q != ST_ON) || (cnt_q == 16'd0));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pwm_cnt_q <= 8'd0;
    end else if (on_load) begin
      pwm_cnt_q <= 8'd0;
    end else if (state_q == ST_ON) begin
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
    end
  end

  assign pwm_on  = (pwm_cnt_q < duty_q);
  assign duty_rd = duty_q;
`else
  assign pwm_on  = 1'b1;
  assign duty_rd = 8'h00;
`endif

  assign run        = scan_en_q && (mask_q != 8'd0);
  assign nxt_idx    = next_set(mask_q, idx_q);
  assign first_idx  = next_set(mask_q, 3'd7);
  assign dwell_load = (dwell_q == 16'd0) ? 16'd0 : dwell_q - 16'd1;
  assign blank_load = {8'd0, blank_q - 8'd1};

  // Scan FSM: counters are loaded with length-1 and expire at zero
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    boundary = 1'b0;
    if (!run) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          idx_d = first_idx;
          if (blank_q == 8'd0) begin
            state_d = ST_ON;
            cnt_d   = dwell_load;
          end else begin
            state_d = ST_BLANK;
            cnt_d   = blank_load;
          end
        end
        ST_BLANK: begin
          if (cnt_q == 16'd0) begin
            state_d = ST_ON;
            cnt_d   = dwell_load;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        ST_ON: begin
          if (cnt_q == 16'd0) begin
            idx_d    = nxt_idx;
            boundary = (nxt_idx <= idx_q);
            if (blank_q == 8'd0) begin
              state_d = ST_ON;
              cnt_d   = dwell_load;
            end else begin
              state_d = ST_BLANK;
              cnt_d   = blank_load;
            end
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // The copy samples the pre-write shadow, so a coincident DIGITS write lands next frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      active_q <= 32'd0;
    end else if (state_q == ST_IDLE || boundary) begin
      active_q <= shadow_q;
    end
  end

  sevseg_hex_decode u_hex (
    .nibble_i (active_q[{idx_q, 2'b00} +: 4]),
    .seg_o    (hex_seg)
  );

  // Gating on run releases the anode on the same cycle a mask or enable clear lands.
  always_comb begin
    an_d  = 8'hFF;
    seg_d = 7'h7F;
    if (state_q == ST_ON) begin
      seg_d = hex_seg;
      if (run && mask_q[idx_q] && pwm_on) an_d[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      an_q    <= 8'hFF;
      seg_q   <= 7'h7F;
      frame_q <= 1'b0;
    end else begin
      an_q    <= an_d;
      seg_q   <= seg_d;
      frame_q <= boundary;
    end
  end

  assign o_wb_ack = ack_q;
  assign o_wb_rdt = rdt_q;
  assign o_an     = an_q;
  assign o_seg    = seg_q;
  assign o_frame  = frame_q;

endmodule

// File: tb/tb_veerwolf_sevseg_scanner.sv
// Directed bench for veerwolf_sevseg_scanner: register access, scan order, skipping,
// tear-free updates, mask/enable edges, zero timing and reset; PWM when SEVSEG_PWM_EN is set.
module tb_veerwolf_sevseg_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [31:0] rdt;
  logic        ack;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        frame;

  int checks = 0;
  int errors = 0;

  logic [6:0] hexc [16] = '{7'b000_0001, 7'b100_1111, 7'b001_0010, 7'b000_0110,
                            7'b100_1100, 7'b010_0100, 7'b010_0000, 7'b000_1111,
                            7'b000_0000, 7'b000_0100, 7'b000_1000, 7'b110_0000,
                            7'b011_0001, 7'b100_0010, 7'b011_0000, 7'b011_1000};

  veerwolf_sevseg_scanner dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_wb_adr (adr),
    .i_wb_dat (dat),
    .i_wb_sel (sel),
    .i_wb_we  (we),
    .i_wb_cyc (cyc),
    .i_wb_stb (stb),
    .o_wb_rdt (rdt),
    .o_wb_ack (ack),
    .o_an     (an),
    .o_seg    (seg),
    .o_frame  (frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    if (ack) step();
    adr = a; dat = d; sel = s; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    step();
    check("wb_write_ack", {31'd0, ack}, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [3:0] a, output logic [31:0] d);
    if (ack) step();
    adr = a; sel = 4'hF; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    step();
    check("wb_read_ack", {31'd0, ack}, 32'd1);
    d = rdt;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (!frame && n < 400);
    check(tag, {31'd0, frame}, 32'd1);
  endtask

  task automatic wait_an(input string tag, input logic [7:0] v);
    int n = 0;
    do begin
      step();
      n++;
    end while (an !== v && n < 400);
    check(tag, {24'd0, an}, {24'd0, v});
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;
    int          d, j;
    int          lows;

    rst = 1'b1; adr = 4'd0; dat = 32'd0; sel = 4'd0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    repeat (3) step();
    check("rst_an", {24'd0, an}, 32'h0000_00FF);
    check("rst_seg", {25'd0, seg}, 32'h0000_007F);
    check("rst_frame", {31'd0, frame}, 32'd0);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_rdt", rdt, 32'd0);
    rst = 1'b0;
    step();
    wb_read(4'h0, rd);  check("rst_ctrl", rd, 32'd0);
    wb_read(4'h8, rd);  check("rst_timing", rd, 32'h0010_C350);
    wb_read(4'h4, rd);  check("rst_digits", rd, 32'd0);
    wb_read(4'hC, rd);
`ifdef SEVSEG_PWM_EN
    check("rst_bright", rd, 32'h0000_00FF);
`else
    check("rst_bright", rd, 32'h0000_0000);
`endif

    // Byte-lane write touches only the blank field
    wb_write(4'h8, 32'hFFFF_FFFF, 4'b0100);
    wb_read(4'h8, rd);  check("lane_timing", rd, 32'h00FF_C350);

    // Full scan: blank 2, dwell 3, all digits
    wb_write(4'h8, 32'h0002_0003, 4'hF);
    wb_write(4'h4, 32'h7654_3210, 4'hF);
    wb_write(4'h0, 32'h0000_01FF, 4'hF);
    wb_read(4'h0, rd);  check("ctrl_rb", rd, 32'h0000_01FF);
    wait_frame("full_sync");
    for (int k = 1; k <= 40; k++) begin
      step();
      d = (k - 1) / 5;
      j = (k - 1) % 5;
      exp_an = 8'hFF;
      exp_seg = 7'h7F;
      if (j >= 2) begin
        exp_an[d] = 1'b0;
        exp_seg = hexc[d];
      end
      check("full_an", {24'd0, an}, {24'd0, exp_an});
      check("full_seg", {25'd0, seg}, {25'd0, exp_seg});
      check("full_frame", {31'd0, frame}, {31'd0, (k == 40)});
    end

    // Skip: only digits 0 and 7
    wb_write(4'h0, 32'h0000_0181, 4'hF);
    wait_frame("skip_sync");
    for (int k = 1; k <= 10; k++) begin
      step();
      d = ((k - 1) / 5 == 0) ? 0 : 7;
      j = (k - 1) % 5;
      exp_an = 8'hFF;
      if (j >= 2) exp_an[d] = 1'b0;
      check("skip_an", {24'd0, an}, {24'd0, exp_an});
      check("skip_frame", {31'd0, frame}, {31'd0, (k == 10)});
    end

    // Tear-free update written while digit 0 is on
    repeat (4) step();
    check("tear_pre_an", {24'd0, an}, 32'h0000_00FE);
    check("tear_pre_seg", {25'd0, seg}, {25'd0, hexc[0]});
    wb_write(4'h4, 32'hFFFF_FFFF, 4'hF);
    wait_an("tear_d7_old", 8'h7F);
    check("tear_seg_old", {25'd0, seg}, {25'd0, hexc[7]});
    wait_frame("tear_frame");
    wait_an("tear_d0_new", 8'hFE);
    check("tear_seg_new0", {25'd0, seg}, {25'd0, hexc[15]});
    wait_an("tear_d7_new", 8'h7F);
    check("tear_seg_new7", {25'd0, seg}, {25'd0, hexc[15]});

    // DIGITS write landing on the frame copy edge
    wait_frame("coinc_sync");
    repeat (9) step();
    wb_write(4'h4, 32'h1000_0002, 4'hF);
    check("coinc_frame", {31'd0, frame}, 32'd1);
    wait_an("coinc_d0", 8'hFE);
    check("coinc_seg0_old", {25'd0, seg}, {25'd0, hexc[15]});
    wait_an("coinc_d7", 8'h7F);
    check("coinc_seg7_old", {25'd0, seg}, {25'd0, hexc[15]});
    wait_frame("coinc_next");
    wait_an("coinc_d0b", 8'hFE);
    check("coinc_seg0_new", {25'd0, seg}, {25'd0, hexc[2]});
    wait_an("coinc_d7b", 8'h7F);
    check("coinc_seg7_new", {25'd0, seg}, {25'd0, hexc[1]});

    // Clear mask[0] while digit 0 is on
    wait_frame("mask_sync");
    repeat (3) step();
    check("mask_pre_an", {24'd0, an}, 32'h0000_00FE);
    wb_write(4'h0, 32'h0000_0180, 4'hF);
    step();
    check("mask_release", {24'd0, an}, 32'h0000_00FF);
    for (int k = 6; k <= 15; k++) begin
      step();
      exp_an = ((k >= 8 && k <= 10) || k >= 13) ? 8'h7F : 8'hFF;
      check("mask_an", {24'd0, an}, {24'd0, exp_an});
      check("mask_frame", {31'd0, frame}, {31'd0, (k == 10 || k == 15)});
    end

    // Clear scan_en while digit 7 is on
    repeat (3) step();
    check("dis_pre_an", {24'd0, an}, 32'h0000_007F);
    wb_write(4'h0, 32'h0000_0080, 4'hF);
    step();
    check("dis_release", {24'd0, an}, 32'h0000_00FF);
    for (int k = 0; k < 5; k++) begin
      step();
      check("dis_idle_an", {24'd0, an}, 32'h0000_00FF);
      check("dis_idle_frame", {31'd0, frame}, 32'd0);
    end
    wb_read(4'h0, rd);  check("dis_ctrl", rd, 32'h0000_0080);
    wb_write(4'hC, 32'h0000_0040, 4'hF);
    wb_read(4'hC, rd);
`ifdef SEVSEG_PWM_EN
    check("bright_rb", rd, 32'h0000_0740);
`else
    check("bright_rb", rd, 32'h0000_0700);
`endif

    // Zero blank and zero dwell: one cycle per digit
    wb_write(4'h8, 32'h0000_0000, 4'hF);
    wb_write(4'h0, 32'h0000_0103, 4'hF);
    wait_frame("zero_sync");
    step();
    check("zero_an1", {24'd0, an}, 32'h0000_00FE);
    check("zero_fr1", {31'd0, frame}, 32'd0);
    step();
    check("zero_an2", {24'd0, an}, 32'h0000_00FD);
    check("zero_fr2", {31'd0, frame}, 32'd1);
    step();
    check("zero_an3", {24'd0, an}, 32'h0000_00FE);

`ifdef SEVSEG_PWM_EN
    // PWM: 256-cycle dwell, duty 64 then 0, single digit
    wb_write(4'h8, 32'h0002_0100, 4'hF);
    wb_write(4'h0, 32'h0000_0101, 4'hF);
    wait_frame("pwm_sync0");
    wait_frame("pwm_sync");
    lows = 0;
    for (int k = 0; k < 258; k++) begin
      step();
      if (an[0] == 1'b0) lows++;
    end
    check("pwm_duty64", lows, 32'd64);
    wb_write(4'hC, 32'h0000_0000, 4'hF);
    wait_frame("pwm_sync2");
    lows = 0;
    for (int k = 0; k < 258; k++) begin
      step();
      if (an != 8'hFF) lows++;
    end
    check("pwm_duty0", lows, 32'd0);
`endif

    // Reset in the middle of a scan
    wb_write(4'h8, 32'h0002_0003, 4'hF);
    wb_write(4'h0, 32'h0000_01FF, 4'hF);
    wait_frame("mrst_sync");
    repeat (7) step();
    rst = 1'b1;
    step();
    check("mrst_an", {24'd0, an}, 32'h0000_00FF);
    check("mrst_seg", {25'd0, seg}, 32'h0000_007F);
    check("mrst_frame", {31'd0, frame}, 32'd0);
    step();
    rst = 1'b0;
    repeat (3) step();
    check("mrst_an_idle", {24'd0, an}, 32'h0000_00FF);
    wb_read(4'h0, rd);  check("mrst_ctrl", rd, 32'd0);
    wb_read(4'h4, rd);  check("mrst_digits", rd, 32'd0);
    wb_read(4'h8, rd);  check("mrst_timing", rd, 32'h0010_C350);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
